// File: rtl/rf_write_arbiter.sv
// Two-requester arbiter for the register-file write port: burst-limited round-robin
// with a registered write. Define RF_ARB_FIXED_PRI_EN for strict req0 priority instead.
module rf_write_arbiter #(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 5,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [WIDTH-1:0]  req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [WIDTH-1:0]  req1_data,
  output logic              req1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_e;

  state_e            state_q, state_d;
  logic              grant0, grant1;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [WIDTH-1:0]  sel_data;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [WIDTH-1:0]  wr_data_q;

`ifndef RF_ARB_FIXED_PRI_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
`endif

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
`ifdef RF_ARB_FIXED_PRI_EN
    grant0 = req0_valid;
    grant1 = req1_valid & ~req0_valid;
`else
    cnt_d  = '0;
    last_d = last_q;
    case (state_q)
      OWN0: begin
        if (req1_valid && (cnt_q == CNT_MAX || !req0_valid)) grant1 = 1'b1;
        else if (req0_valid)                                 grant0 = 1'b1;
      end
      OWN1: begin
        if (req0_valid && (cnt_q == CNT_MAX || !req1_valid)) grant0 = 1'b1;
        else if (req1_valid)                                 grant1 = 1'b1;
      end
      default: begin
        // last_q==1 means req1 won last, so req0 takes a tie.
        if (req0_valid && req1_valid) begin
          grant0 = last_q;
          grant1 = ~last_q;
        end else begin
          grant0 = req0_valid;
          grant1 = req1_valid;
        end
      end
    endcase

    // Continuing the same owner counts up (saturating); a new owner restarts at 1.
    if (grant0) begin
      last_d = 1'b0;
      if (state_q == OWN0) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      else                 cnt_d = CNT_ONE;
    end else if (grant1) begin
      last_d = 1'b1;
      if (state_q == OWN1) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      else                 cnt_d = CNT_ONE;
    end
`endif
    if (grant0)      state_d = OWN0;
    else if (grant1) state_d = OWN1;
    else             state_d = IDLE;
  end

  assign req0_ready = grant0 & rst_n;
  assign req1_ready = grant1 & rst_n;
  assign xfer       = grant0 | grant1;
  assign sel_addr   = grant1 ? req1_addr : req0_addr;
  assign sel_data   = grant1 ? req1_data : req0_data;
  // Writes to r0 are consumed but never enabled on the register file.
  assign wr_en_d    = xfer && (sel_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      wr_en_q <= wr_en_d;
      if (xfer) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
      end
    end
  end

`ifndef RF_ARB_FIXED_PRI_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      last_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end
`endif

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign owner   = state_q;

endmodule
